// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, default frame shape and the shared baud period
// for the UART transmitter, its baud generator and its bench.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      START  = 3'd2,
      DATA   = 3'd3,
      PARITY = 3'd4,
      STOP   = 3'd5
   } uart_state_t;

   localparam int DEF_DATA_BITS = 8;
   localparam int DEF_STOP_BITS = 1;
   localparam int TICK_PERIOD   = 20;

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready byte handshake between a producer and the
// UART transmitter.
interface uart_tx_if #(
   parameter int DATA_BITS = 8
);

   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );

endinterface

// File: rtl/uart_tx.sv
// uart_tx: tick-paced start/data/stop serialiser, LSB first.
// Define UART_TX_PARITY_EN to add a parity bit after the data bits.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = DEF_DATA_BITS,
   parameter int STOP_BITS  = DEF_STOP_BITS,
   parameter int PARITY_ODD = 0
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     tick,
   uart_tx_if.slave host,
   output logic     tx,
   output logic     busy
);

   localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);
   localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
      $error("uart_tx: DATA_BITS must be 5..8");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end
   if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
      $error("uart_tx: PARITY_ODD must be 0 or 1");
   end

   uart_state_t          state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [CW-1:0]        bitcnt_q, bitcnt_d;
   logic                 stopcnt_q, stopcnt_d;
   logic                 tx_q, tx_d;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
   logic                 parity_q, parity_d;
`endif

   logic [DATA_BITS-1:0] shift_next;

   assign shift_next = {1'b0, shift_q[DATA_BITS-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bitcnt_q  <= '0;
         stopcnt_q <= 1'b0;
         tx_q      <= 1'b1;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bitcnt_q  <= bitcnt_d;
         stopcnt_q <= stopcnt_d;
         tx_q      <= tx_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bitcnt_d  = bitcnt_q;
      stopcnt_d = stopcnt_q;
      tx_d      = tx_q;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      unique case (state_q)
         // Accept is the only move not paced by tick.
         IDLE: begin
            tx_d = 1'b1;
            if (host.tx_valid && ready_q) begin
               shift_d = host.tx_data;
               state_d = LOAD;
`ifdef UART_TX_PARITY_EN
               parity_d = (^host.tx_data) ^ PARITY_ODD[0];
`endif
            end
         end
         LOAD: begin
            if (tick) begin
               tx_d    = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (tick) begin
               tx_d     = shift_q[0];
               shift_d  = shift_next;
               bitcnt_d = '0;
               state_d  = DATA;
            end
         end
         DATA: begin
            if (tick) begin
               if (bitcnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                  tx_d    = parity_q;
                  state_d = PARITY;
`else
                  tx_d      = 1'b1;
                  stopcnt_d = 1'b0;
                  state_d   = STOP;
`endif
               end else begin
                  tx_d     = shift_q[0];
                  shift_d  = shift_next;
                  bitcnt_d = bitcnt_q + 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (tick) begin
               tx_d      = 1'b1;
               stopcnt_d = 1'b0;
               state_d   = STOP;
            end
         end
`endif
         STOP: begin
            if (tick) begin
               if (stopcnt_q == LAST_STOP) begin
                  state_d = IDLE;
               end else begin
                  stopcnt_d = stopcnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   // Handshake flags follow the next state so they line up with tx.
   always_comb begin
      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
   end

   assign tx            = tx_q;
   assign busy          = busy_q;
   assign host.tx_ready = ready_q;

`ifndef SYNTHESIS
   a_tx_on_tick : assert property (
      @(posedge clk) disable iff (rst)
      $changed(tx) |-> ($past(tick) || $past(rst))
   );
   a_ready_busy : assert property (
      @(posedge clk) disable iff (rst)
      host.tx_ready == !busy
   );
`endif

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized scoreboard bench; a line monitor decodes frames
// and compares each bit period against a bit-list model of the frame.
module tb_uart_tx;
   import uart_pkg::*;

   localparam int DB  = DEF_DATA_BITS;
   localparam int SB  = DEF_STOP_BITS;
   localparam int ODD = 0;
   localparam int TP  = TICK_PERIOD;
`ifdef UART_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int FB = 1 + DB + PB + SB;

   typedef struct {
      logic [DB-1:0] data;
      int            acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tick = 1'b0;
   logic tx;
   logic busy;

   int   cyc = 0;
   int   tcnt = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];
   int   starts[$];
   int   cur_bit = -1;
   bit   in_frame = 1'b0;

   uart_tx_if #(.DATA_BITS(DB)) bus ();

   uart_tx #(
      .DATA_BITS (DB),
      .STOP_BITS (SB),
      .PARITY_ODD(ODD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .tick(tick),
      .host(bus),
      .tx  (tx),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Free-running baud tick: one high cycle every TP cycles.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         tcnt = (tcnt + 1) % TP;
         tick = (tcnt == TP - 1);
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input bit ok, input string name,
                        input int act, input int exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Frame model: bit i of the serial frame for byte d.
   function automatic logic frame_bit(input logic [DB-1:0] d, input int i);
      if (i == 0) return 1'b0;
      if (i <= DB) return logic'((d >> (i - 1)) & 1);
      if (PB == 1 && i == DB + 1) return logic'(($countones(d) + ODD) % 2);
      return 1'b1;
   endfunction

   // Monitor: each start edge pops one expected byte and checks the frame.
   initial begin
      logic prev;
      exp_t e;
      bit   abort;
      int   bad;
      int   lat;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev = 1'b1;
         end else if (prev && !tx) begin
            in_frame = 1'b1;
            abort = 1'b0;
            starts.push_back(cyc);
            if (sb.size() == 0) begin
               check(1'b0, "unexpected_frame", 1, 0);
               prev = tx;
               in_frame = 1'b0;
            end else begin
               e = sb.pop_front();
               lat = cyc - e.acc;
               check(lat >= 1 && lat <= TP, "start_latency", lat, TP);
               for (int b = 0; b < FB && !abort; b++) begin
                  cur_bit = b;
                  bad = 0;
                  for (int c = 0; c < TP; c++) begin
                     if (b != 0 || c != 0) @(negedge clk);
                     if (rst) begin
                        abort = 1'b1;
                        break;
                     end
                     if (tx !== frame_bit(e.data, b) || busy !== 1'b1)
                        bad++;
                  end
                  if (!abort)
                     check(bad == 0, $sformatf("frame_bit%0d_bad_cycles", b),
                           bad, 0);
               end
               if (!abort) begin
                  @(negedge clk);
                  if (!rst)
                     check(bus.tx_ready === 1'b1 && busy === 1'b0,
                           "idle_after_stop",
                           int'({bus.tx_ready, busy}), 2);
               end
               cur_bit = -1;
               in_frame = 1'b0;
               prev = 1'b1;
            end
         end else begin
            prev = tx;
         end
      end
   end

   task automatic send(input logic [DB-1:0] d, input bit hold,
                       output int acc);
      acc = -1;
      bus.tx_data = d;
      bus.tx_valid = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if (bus.tx_ready === 1'b1) begin
            acc = cyc + 1;
            sb.push_back('{d, acc});
            @(negedge clk);
            bus.tx_valid = hold;
            bus.tx_data = DB'($urandom);
            return;
         end
         @(negedge clk);
      end
      bus.tx_valid = 1'b0;
      check(1'b0, "accept_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         if (!busy && !in_frame && sb.size() == 0 && bus.tx_ready) return;
      end
      check(1'b0, "idle_timeout", int'(busy), 0);
   endtask

   initial begin
      int acc;
      int gap;
      bus.tx_valid = 1'b0;
      bus.tx_data = '0;

      // Reset held with the tick running.
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check(tx === 1'b1 && bus.tx_ready === 1'b1 && busy === 1'b0,
               "reset_outputs", int'({tx, bus.tx_ready, busy}), 6);
      end
      rst = 1'b0;
      @(negedge clk);
      check(tx === 1'b1 && bus.tx_ready === 1'b1 && busy === 1'b0,
            "after_reset", int'({tx, bus.tx_ready, busy}), 6);

      // Single byte.
      send(DB'(8'hA5), 1'b0, acc);
      wait_idle();

      // Back-to-back with valid held across frames.
      send(DB'(8'h00), 1'b1, acc);
      send(DB'(8'hFF), 1'b0, acc);
      check(bus.tx_ready === 1'b0, "ready_one_clk", int'(bus.tx_ready), 0);
      wait_idle();
      if (starts.size() >= 2)
         check(starts[starts.size()-1] - starts[starts.size()-2]
               == (FB + 1) * TP, "b2b_start_spacing",
               starts[starts.size()-1] - starts[starts.size()-2],
               (FB + 1) * TP);
      else
         check(1'b0, "b2b_frames_seen", starts.size(), 2);

      // Accept on a tick cycle: that tick must be ignored.
      begin
         bit found = 1'b0;
         for (int i = 0; i < 4 * TP && !found; i++) begin
            @(negedge clk);
            if (tick && bus.tx_ready) found = 1'b1;
         end
         check(found, "tick_align_found", int'(found), 1);
         if (found) begin
            logic [DB-1:0] d = DB'($urandom);
            bus.tx_data = d;
            bus.tx_valid = 1'b1;
            acc = cyc + 1;
            sb.push_back('{d, acc});
            @(negedge clk);
            bus.tx_valid = 1'b0;
            wait_idle();
            check(starts[starts.size()-1] - acc == TP, "tick_accept_latency",
                  starts[starts.size()-1] - acc, TP);
         end
      end

      // Reset in data bit 3, then a clean frame.
      send(DB'($urandom), 1'b0, acc);
      begin
         bit hit = 1'b0;
         for (int i = 0; i < 20 * TP && !hit; i++) begin
            @(negedge clk);
            if (cur_bit == 4) hit = 1'b1;
         end
         check(hit, "reach_data_bit3", cur_bit, 4);
      end
      rst = 1'b1;
      @(negedge clk);
      check(tx === 1'b1 && bus.tx_ready === 1'b1 && busy === 1'b0,
            "reset_mid_frame", int'({tx, bus.tx_ready, busy}), 6);
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      @(negedge clk);
      send(DB'(8'h3C), 1'b0, acc);
      wait_idle();

      // Random traffic, gaps and abandoned valid pulses.
      for (int n = 0; n < 25; n++) begin
         gap = $urandom_range(0, 3 * TP);
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            if (bus.tx_ready === 1'b0 && ($urandom % 4) == 0) begin
               bus.tx_valid = 1'b1;
               bus.tx_data = DB'($urandom);
               @(negedge clk);
               bus.tx_valid = 1'b0;
            end
         end
         send(DB'($urandom), 1'($urandom % 2), acc);
         bus.tx_valid = 1'b0;
      end
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
